// File: rtl/ddr4_iod_bg_tx_ctrl_if.sv
// rtl/ddr4_iod_bg_tx_ctrl_if.sv - command stream and delay-adjust request/status bundle
interface ddr4_iod_bg_tx_ctrl_if;
   logic       CMD_VALID;
   logic [3:0] CMD_DATA;
   logic       CMD_OE;
   logic       DLY_REQ;
   logic       DLY_DIR;
   logic [6:0] DLY_STEPS;
   logic       DLY_LOAD_REQ;
   logic       DLY_BUSY;
   logic       DLY_DONE;
   logic       DLY_ERR;
   logic [6:0] DLY_TAP;

   modport master (
      output CMD_VALID, CMD_DATA, CMD_OE, DLY_REQ, DLY_DIR, DLY_STEPS, DLY_LOAD_REQ,
      input  DLY_BUSY, DLY_DONE, DLY_ERR, DLY_TAP
   );

   modport slave (
      input  CMD_VALID, CMD_DATA, CMD_OE, DLY_REQ, DLY_DIR, DLY_STEPS, DLY_LOAD_REQ,
      output DLY_BUSY, DLY_DONE, DLY_ERR, DLY_TAP
   );
endinterface

// File: rtl/ddr4_iod_bg_tx_ctrl.sv
// rtl/ddr4_iod_bg_tx_ctrl.sv - IOD byte-group TX datapath with output-enable tail and delay-line adjust engine
module ddr4_iod_bg_tx_ctrl #(
   parameter logic [3:0] IDLE_DATA = 4'b0000,
   parameter int         OE_POST   = 1,
   parameter logic [6:0] TAP_INIT  = 7'd1,
   parameter logic [6:0] TAP_MAX   = 7'd127,
   parameter int         MOVE_GAP  = 3
) (
   input  logic                    FAB_CLK,
   input  logic                    SYNC_RST,
   ddr4_iod_bg_tx_ctrl_if.slave    ctl,
   output logic [3:0]              TX_DATA_0,
   output logic [3:0]              OE_DATA_0,
   output logic                    DELAY_LINE_MOVE_0,
   output logic                    DELAY_LINE_DIRECTION_0,
   output logic                    DELAY_LINE_LOAD_0,
   input  logic                    DELAY_LINE_OUT_OF_RANGE_0
);

   localparam logic [2:0] OE_POST_W = 3'(OE_POST);
   localparam logic [3:0] GAP_W     = 4'(MOVE_GAP);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_DONE} state_t;

   logic [2:0] oe_cnt;
   state_t     state;
   logic [6:0] tap;
   logic [6:0] rem;
   logic [3:0] gap_cnt;
   logic       dir_l;
   logic       from_load;
   logic       busy;
   logic       done;
   logic       err;

   assign ctl.DLY_BUSY = busy;
   assign ctl.DLY_DONE = done;
   assign ctl.DLY_ERR  = err;
   assign ctl.DLY_TAP  = tap;

   // While CMD_OE is high the tail counter is kept preloaded, so its fall starts the tail directly.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         TX_DATA_0 <= IDLE_DATA;
         OE_DATA_0 <= 4'b0000;
         oe_cnt    <= 3'd0;
      end else begin
         TX_DATA_0 <= ctl.CMD_VALID ? ctl.CMD_DATA : IDLE_DATA;
         if (ctl.CMD_OE) begin
            OE_DATA_0 <= 4'b1111;
            oe_cnt    <= OE_POST_W;
         end else if (oe_cnt != 3'd0) begin
            OE_DATA_0 <= 4'b1111;
            oe_cnt    <= oe_cnt - 3'd1;
         end else begin
            OE_DATA_0 <= 4'b0000;
         end
      end
   end

   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state                  <= S_IDLE;
         tap                    <= TAP_INIT;
         rem                    <= 7'd0;
         gap_cnt                <= 4'd0;
         dir_l                  <= 1'b0;
         from_load              <= 1'b0;
         busy                   <= 1'b0;
         done                   <= 1'b0;
         err                    <= 1'b0;
         DELAY_LINE_MOVE_0      <= 1'b0;
         DELAY_LINE_LOAD_0      <= 1'b0;
         DELAY_LINE_DIRECTION_0 <= 1'b0;
      end else begin
         DELAY_LINE_MOVE_0 <= 1'b0;
         DELAY_LINE_LOAD_0 <= 1'b0;
         done              <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ctl.DLY_LOAD_REQ) begin
                  state             <= S_LOAD;
                  busy              <= 1'b1;
                  err               <= 1'b0;
                  from_load         <= 1'b1;
                  tap               <= TAP_INIT;
                  DELAY_LINE_LOAD_0 <= 1'b1;
               end else if (ctl.DLY_REQ) begin
                  err       <= 1'b0;
                  from_load <= 1'b0;
                  dir_l     <= ctl.DLY_DIR;
                  rem       <= ctl.DLY_STEPS;
                  if (ctl.DLY_STEPS == 7'd0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_SETUP;
                     busy  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               state   <= S_GAP;
               gap_cnt <= GAP_W;
            end
            S_SETUP: begin
               DELAY_LINE_DIRECTION_0 <= dir_l;
               state                  <= S_MOVE;
            end
            // Bound is checked before pulsing so the IOD never sees a move past either end.
            S_MOVE: begin
               if (dir_l ? (tap == TAP_MAX) : (tap == 7'd0)) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  DELAY_LINE_MOVE_0 <= 1'b1;
                  tap               <= dir_l ? tap + 7'd1 : tap - 7'd1;
                  rem               <= rem - 7'd1;
                  gap_cnt           <= GAP_W;
                  state             <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd1) begin
                  if (DELAY_LINE_OUT_OF_RANGE_0 || rem == 7'd0 || from_load) begin
                     err   <= err | DELAY_LINE_OUT_OF_RANGE_0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     state <= S_MOVE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr4_iod_bg_tx_ctrl.sv
// tb/tb_ddr4_iod_bg_tx_ctrl.sv - randomized self-checking bench for ddr4_iod_bg_tx_ctrl
module tb_ddr4_iod_bg_tx_ctrl;
   localparam logic [3:0] IDLE_DATA = 4'b0000;
   localparam int         OE_POST   = 1;
   localparam int         TAP_INIT  = 1;
   localparam int         TAP_MAX   = 127;
   localparam int         G         = 3;

   logic       FAB_CLK = 1'b0;
   logic       SYNC_RST;
   logic [3:0] TX_DATA_0;
   logic [3:0] OE_DATA_0;
   logic       mv;
   logic       dr;
   logic       ld;
   logic       oor;

   int n_cmp = 0;
   int n_bad = 0;
   int model_tap;
   bit oe_hist[$];

   ddr4_iod_bg_tx_ctrl_if ctl();

   ddr4_iod_bg_tx_ctrl #(
      .IDLE_DATA (IDLE_DATA),
      .OE_POST   (OE_POST),
      .TAP_INIT  (7'(TAP_INIT)),
      .TAP_MAX   (7'(TAP_MAX)),
      .MOVE_GAP  (G)
   ) dut (
      .FAB_CLK                   (FAB_CLK),
      .SYNC_RST                  (SYNC_RST),
      .ctl                       (ctl.slave),
      .TX_DATA_0                 (TX_DATA_0),
      .OE_DATA_0                 (OE_DATA_0),
      .DELAY_LINE_MOVE_0         (mv),
      .DELAY_LINE_DIRECTION_0    (dr),
      .DELAY_LINE_LOAD_0         (ld),
      .DELAY_LINE_OUT_OF_RANGE_0 (oor)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Datapath reference: one-cycle register for TX, OE high if CMD_OE was high in any of the last OE_POST+1 cycles.
   task automatic tick();
      logic [3:0] etx;
      logic [3:0] eoe;
      eoe = 4'b0000;
      if (SYNC_RST) begin
         etx = IDLE_DATA;
         oe_hist.delete();
      end else begin
         etx = ctl.CMD_VALID ? ctl.CMD_DATA : IDLE_DATA;
         oe_hist.push_back(ctl.CMD_OE);
         if (oe_hist.size() > OE_POST + 1) void'(oe_hist.pop_front());
         foreach (oe_hist[i]) if (oe_hist[i]) eoe = 4'b1111;
      end
      @(posedge FAB_CLK);
      #1;
      check("tx_data", 32'(TX_DATA_0), 32'(etx));
      check("oe_data", 32'(OE_DATA_0), 32'(eoe));
      ctl.CMD_VALID = 1'($urandom_range(0, 1));
      ctl.CMD_DATA  = 4'($urandom);
      ctl.CMD_OE    = ($urandom_range(0, 3) == 0);
   endtask

   task automatic clear_reqs();
      ctl.DLY_REQ      = 1'b0;
      ctl.DLY_LOAD_REQ = 1'b0;
      ctl.DLY_DIR      = 1'b0;
      ctl.DLY_STEPS    = 7'd0;
      oor              = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 32'(ctl.DLY_BUSY), 0);
      check({tag, "_done"}, 32'(ctl.DLY_DONE), 0);
      check({tag, "_err"},  32'(ctl.DLY_ERR), 0);
      check({tag, "_tap"},  32'(ctl.DLY_TAP), 32'(TAP_INIT));
      check({tag, "_move"}, 32'(mv), 0);
      check({tag, "_load"}, 32'(ld), 0);
      check({tag, "_dir"},  32'(dr), 0);
   endtask

   // Request outcome is predicted from the tap range and gap timing rules; r counts cycles after acceptance.
   task automatic run_req(input bit is_load, input bit both, input bit dir, input int steps, input int oor_gap);
      int navail, p, exp_tap, exp_done_r, w_lo, w_hi, r, done_r, n_mv, n_ld;
      bit exp_err, range_err, hit;
      w_lo = 0; w_hi = -1; hit = 0; p = 0;
      if (is_load) begin
         hit = (oor_gap == 0);
         w_lo = 1; w_hi = G;
         exp_tap = TAP_INIT; exp_err = hit; exp_done_r = G + 1;
      end else if (steps == 0) begin
         exp_tap = model_tap; exp_err = 0; exp_done_r = 0;
      end else begin
         navail = dir ? TAP_MAX - model_tap : model_tap;
         p = (steps < navail) ? steps : navail;
         range_err = (steps > navail);
         hit = (oor_gap >= 0) && (oor_gap < p);
         if (hit) begin
            p = oor_gap + 1;
            w_lo = 2 + oor_gap * (G + 1);
            w_hi = w_lo + G - 1;
         end
         exp_err = hit || range_err;
         exp_tap = dir ? model_tap + p : model_tap - p;
         if (p == 0) exp_done_r = 2;
         else exp_done_r = 2 + (p - 1) * (G + 1) + G + ((range_err && !hit) ? 1 : 0);
      end

      ctl.DLY_REQ      = !is_load || both;
      ctl.DLY_LOAD_REQ = is_load;
      ctl.DLY_DIR      = dir;
      ctl.DLY_STEPS    = 7'(steps);
      tick();
      clear_reqs();
      r = 0; done_r = -1; n_mv = 0; n_ld = 0;
      while (r <= exp_done_r + 40) begin
         if (mv) begin
            check("move_time", 32'(r), 32'(2 + n_mv * (G + 1)));
            check("move_dir", 32'(dr), 32'(dir));
            n_mv++;
         end
         if (ld) begin
            check("load_time", 32'(r), 0);
            n_ld++;
         end
         if (r == 0) begin
            check("busy_accept", 32'(ctl.DLY_BUSY), 32'(exp_done_r != 0));
            if (exp_done_r != 0) check("err_clear", 32'(ctl.DLY_ERR), 0);
         end
         if (ctl.DLY_DONE) begin
            done_r = r;
            break;
         end
         oor = hit && (r >= w_lo) && (r <= w_hi);
         if (r < exp_done_r) begin
            ctl.DLY_REQ      = ($urandom_range(0, 5) == 0);
            ctl.DLY_LOAD_REQ = ($urandom_range(0, 7) == 0);
            ctl.DLY_DIR      = 1'($urandom_range(0, 1));
            ctl.DLY_STEPS    = 7'($urandom_range(1, 9));
         end
         tick();
         clear_reqs();
         r++;
      end
      check("done_time", 32'(done_r), 32'(exp_done_r));
      check("err_at_done", 32'(ctl.DLY_ERR), 32'(exp_err));
      check("tap_at_done", 32'(ctl.DLY_TAP), 32'(exp_tap));
      check("busy_at_done", 32'(ctl.DLY_BUSY), 0);
      check("move_count", 32'(n_mv), 32'(p));
      check("load_count", 32'(n_ld), 32'(is_load));
      clear_reqs();
      tick();
      check("done_width", 32'(ctl.DLY_DONE), 0);
      check("err_sticky", 32'(ctl.DLY_ERR), 32'(exp_err));
      model_tap = exp_tap;
   endtask

   initial begin
      ctl.CMD_VALID = 1'b0;
      ctl.CMD_DATA  = 4'd0;
      ctl.CMD_OE    = 1'b0;
      clear_reqs();
      SYNC_RST = 1'b1;
      ctl.DLY_REQ = 1'b1;
      ctl.DLY_STEPS = 7'd2;
      tick();
      ctl.DLY_LOAD_REQ = 1'b1;
      tick();
      check_reset_state("reset");
      clear_reqs();
      SYNC_RST = 1'b0;
      model_tap = TAP_INIT;
      tick();
      check("idle_busy", 32'(ctl.DLY_BUSY), 0);

      // Simultaneous requests resolve to a load; reset in its gap aborts without a done pulse.
      ctl.DLY_REQ = 1'b1; ctl.DLY_LOAD_REQ = 1'b1; ctl.DLY_DIR = 1'b1; ctl.DLY_STEPS = 7'd5;
      tick();
      clear_reqs();
      check("both_load_pulse", 32'(ld), 1);
      check("both_no_move", 32'(mv), 0);
      tick();
      check("both_load_width", 32'(ld), 0);
      check("both_busy", 32'(ctl.DLY_BUSY), 1);
      tick();
      SYNC_RST = 1'b1;
      ctl.DLY_REQ = 1'b1;
      tick();
      check_reset_state("abort");
      clear_reqs();
      SYNC_RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_done", 32'(ctl.DLY_DONE), 0);
         check("abort_no_move", 32'(mv), 0);
      end
      model_tap = TAP_INIT;

      run_req(0, 0, 1, 3, -1);
      run_req(1, 0, 0, 0, -1);
      run_req(0, 0, 0, 5, -1);
      run_req(1, 0, 0, 0, -1);
      run_req(0, 0, 1, 4, 0);
      run_req(0, 0, 1, 0, -1);
      run_req(1, 1, 0, 0, 0);

      for (int t = 0; t < 60; t++) begin
         bit is_load;
         int steps;
         int og;
         is_load = ($urandom_range(0, 4) == 0);
         steps = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
         og = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_req(is_load, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), steps, og);
         for (int k = int'($urandom_range(0, 3)); k > 0; k--) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
